// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak de-padder.
// Holds the block geometry, the pad10*1 byte markers, the de-padder state
// encoding and a byte-select helper (byte0 is the most significant byte).
package keccak_pkg;

    localparam int RATE_WORDS = 34;
    localparam int CNT_W      = 6;

    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ZERO = 2'd1,
        TAIL = 2'd2
    } state_t;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            2'd3:    word_byte = w[7:0];
            default: word_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/keccak_last_byte.sv
// Locates the last nonzero byte of a word (byte0 = word[31:24]).
// Ports:
//   word  - input word
//   idx   - index 0..3 of the last nonzero byte (0 when the word is zero)
//   nz    - word has at least one nonzero byte
//   trunc - word keeping bytes 0..idx-1, bytes idx..3 forced to zero
module keccak_last_byte (
    input  logic [31:0] word,
    output logic [1:0]  idx,
    output logic        nz,
    output logic [31:0] trunc
);

    // Priority search from the least significant (last) byte backwards.
    always_comb begin
        idx = 2'd0;
        nz  = 1'b0;
        if (word[7:0] != 8'h00) begin
            idx = 2'd3;
            nz  = 1'b1;
        end else if (word[15:8] != 8'h00) begin
            idx = 2'd2;
            nz  = 1'b1;
        end else if (word[23:16] != 8'h00) begin
            idx = 2'd1;
            nz  = 1'b1;
        end else if (word[31:24] != 8'h00) begin
            idx = 2'd0;
            nz  = 1'b1;
        end else begin
            idx = 2'd0;
            nz  = 1'b0;
        end
    end

    // Keep only the bytes in front of the selected index.
    always_comb begin
        trunc = 32'h0000_0000;
        case (idx)
            2'd0:    trunc = 32'h0000_0000;
            2'd1:    trunc = {word[31:24], 24'h00_0000};
            2'd2:    trunc = {word[31:16], 16'h0000};
            2'd3:    trunc = {word[31:8], 8'h00};
            default: trunc = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/keccak_depadder.sv
// Strips Keccak pad10*1 padding from a stream of 32-bit words.
// Ports:
//   clk, reset                   - rising-edge clock, async active-low reset
//   in, in_valid, in_ready       - padded word stream (byte0 = in[31:24])
//   in_last_block                - word belongs to the final block
//   out, out_bytes, out_last     - message word, valid byte count, last beat
//   out_valid, out_ready         - output handshake
//   pad_error                    - one-cycle pulse on malformed padding
// Words are held one deep in pend so the word carrying the pad can be
// truncated; zero words of the final block are only counted (zcnt) because
// they are either message data or padding, which is known only at block end.
module keccak_depadder
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in,
    input  logic        in_valid,
    input  logic        in_last_block,
    output logic        in_ready,
    output logic [31:0] out,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pad_error
);

    state_t           state_r;
    logic [31:0]      pend_r;
    logic             pend_v_r;
    logic             pend_fin_r;
    logic [31:0]      hold_r;
    logic [1:0]       hold_k_r;
    logic             hold_tail_r;
    logic [CNT_W-1:0] zcnt_r;
    logic [CNT_W-1:0] widx_r;

    logic        slot_free_s;
    logic        accept_s;
    logic        blk_end_s;
    logic        word_nz_s;
    logic        pad_bit_s;
    logic [31:0] wp_s;
    logic [1:0]  w_idx_s;
    logic        w_nz_s;
    logic [31:0] w_trunc_s;
    logic [1:0]  p_idx_s;
    logic        p_nz_s;
    logic [31:0] p_trunc_s;
    logic        w_pad_ok_s;
    logic        p_pad_ok_s;
    logic        fin_err_s;

    assign slot_free_s = !out_valid || out_ready;
    assign in_ready    = (state_r == RUN) && slot_free_s;
    assign accept_s    = in_valid && in_ready;
    assign blk_end_s   = (widx_r == CNT_W'(RATE_WORDS - 1));
    assign word_nz_s   = (in != 32'h0000_0000);
    assign pad_bit_s   = ((in[7:0] & PAD_LAST) != 8'h00);
    assign wp_s        = {in[31:8], in[7:0] & ~PAD_LAST};

    keccak_last_byte u_lb_word (
        .word  (wp_s),
        .idx   (w_idx_s),
        .nz    (w_nz_s),
        .trunc (w_trunc_s)
    );

    keccak_last_byte u_lb_pend (
        .word  (pend_r),
        .idx   (p_idx_s),
        .nz    (p_nz_s),
        .trunc (p_trunc_s)
    );

    assign w_pad_ok_s = (word_byte(wp_s, w_idx_s) == PAD_FIRST);
    assign p_pad_ok_s = pend_v_r && pend_fin_r && p_nz_s &&
                        (word_byte(pend_r, p_idx_s) == PAD_FIRST);

    // Padding check for the word closing the final block.
    always_comb begin
        fin_err_s = 1'b0;
        if (!pad_bit_s) begin
            fin_err_s = 1'b1;
        end else if (w_nz_s) begin
            fin_err_s = !w_pad_ok_s;
        end else begin
            fin_err_s = !p_pad_ok_s;
        end
    end

    // Control FSM, buffers and registered output beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            pend_r      <= 32'h0000_0000;
            pend_v_r    <= 1'b0;
            pend_fin_r  <= 1'b0;
            hold_r      <= 32'h0000_0000;
            hold_k_r    <= 2'd0;
            hold_tail_r <= 1'b0;
            zcnt_r      <= {CNT_W{1'b0}};
            widx_r      <= {CNT_W{1'b0}};
            out         <= 32'h0000_0000;
            out_bytes   <= 3'd0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            pad_error   <= 1'b0;
        end else begin
            pad_error <= 1'b0;
            // A consumed beat disappears unless a new one is loaded below.
            if (slot_free_s) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                RUN: begin
                    if (accept_s) begin
                        widx_r <= blk_end_s ? {CNT_W{1'b0}} : widx_r + CNT_W'(1);
                        if (!in_last_block) begin
                            if (pend_v_r) begin
                                out       <= pend_r;
                                out_bytes <= 3'd4;
                                out_last  <= 1'b0;
                                out_valid <= 1'b1;
                            end
                            pend_r     <= in;
                            pend_v_r   <= 1'b1;
                            pend_fin_r <= 1'b0;
                        end else if (!blk_end_s) begin
                            if (word_nz_s) begin
                                if (pend_v_r) begin
                                    out       <= pend_r;
                                    out_bytes <= 3'd4;
                                    out_last  <= 1'b0;
                                    out_valid <= 1'b1;
                                end
                                if (zcnt_r != {CNT_W{1'b0}}) begin
                                    // Counted zeros precede this word: replay them first.
                                    hold_r      <= in;
                                    hold_tail_r <= 1'b0;
                                    pend_v_r    <= 1'b0;
                                    state_r     <= ZERO;
                                end else begin
                                    pend_r     <= in;
                                    pend_v_r   <= 1'b1;
                                    pend_fin_r <= 1'b1;
                                end
                            end else begin
                                zcnt_r <= zcnt_r + CNT_W'(1);
                            end
                        end else if (fin_err_s) begin
                            pad_error  <= 1'b1;
                            pend_v_r   <= 1'b0;
                            pend_fin_r <= 1'b0;
                            zcnt_r     <= {CNT_W{1'b0}};
                        end else if (w_nz_s) begin
                            // Pad start lies in the closing word itself.
                            if (pend_v_r) begin
                                out       <= pend_r;
                                out_bytes <= 3'd4;
                                out_last  <= 1'b0;
                                out_valid <= 1'b1;
                            end
                            pend_v_r    <= 1'b0;
                            hold_r      <= w_trunc_s;
                            hold_k_r    <= w_idx_s;
                            hold_tail_r <= 1'b1;
                            state_r     <= (zcnt_r != {CNT_W{1'b0}}) ? ZERO : TAIL;
                        end else begin
                            // Pad start lies in pend; the zero run was padding.
                            out        <= p_trunc_s;
                            out_bytes  <= {1'b0, p_idx_s};
                            out_last   <= 1'b1;
                            out_valid  <= 1'b1;
                            pend_v_r   <= 1'b0;
                            pend_fin_r <= 1'b0;
                            zcnt_r     <= {CNT_W{1'b0}};
                        end
                    end
                end
                ZERO: begin
                    if (slot_free_s) begin
                        out       <= 32'h0000_0000;
                        out_bytes <= 3'd4;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        zcnt_r    <= zcnt_r - CNT_W'(1);
                        if (zcnt_r == CNT_W'(1)) begin
                            if (hold_tail_r) begin
                                state_r <= TAIL;
                            end else begin
                                pend_r     <= hold_r;
                                pend_v_r   <= 1'b1;
                                pend_fin_r <= 1'b1;
                                state_r    <= RUN;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (slot_free_s) begin
                        out        <= hold_r;
                        out_bytes  <= {1'b0, hold_k_r};
                        out_last   <= 1'b1;
                        out_valid  <= 1'b1;
                        pend_v_r   <= 1'b0;
                        pend_fin_r <= 1'b0;
                        zcnt_r     <= {CNT_W{1'b0}};
                        state_r    <= RUN;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_depadder.sv
// Bench for keccak_depadder: messages are padded here from raw bytes and the
// expected beats are derived from the message bytes alone.
module tb_keccak_depadder;

    logic        clk;
    logic        reset;
    logic [31:0] in;
    logic        in_valid;
    logic        in_last_block;
    logic        in_ready;
    logic [31:0] out;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        pad_error;

    keccak_depadder dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .in_valid      (in_valid),
        .in_last_block (in_last_block),
        .in_ready      (in_ready),
        .out           (out),
        .out_bytes     (out_bytes),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pad_error     (pad_error)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] tx_w[$];
    logic        tx_lb[$];
    logic [7:0]  msg[$];
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          perr_cnt = 0;
    int          perr_base = 0;
    int          rdy_mode = 0;
    bit          gap_en = 1'b1;
    bit          stall_seen = 1'b0;
    logic [36:0] stall_val;
    logic [31:0] e_first[3];
    logic [31:0] e_last[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sink ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
            else out_ready = 1'b0;
        end
    end

    // Output monitor: collects beats, counts error pulses, checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen)
                    chk("hold_stable", 64'({out, out_bytes, out_last, out_valid}), 64'(stall_val));
                if (out_valid && out_ready) got_q.push_back({out, out_bytes, out_last});
                if (pad_error) perr_cnt++;
                stall_seen = out_valid && !out_ready;
                stall_val  = {out, out_bytes, out_last, out_valid};
            end
        end
    end

    // Pad msg into blocks and derive the expected beats from the raw bytes.
    task automatic load_msg();
        int L;
        int nb;
        int r;
        logic [7:0]  p[$];
        logic [31:0] t;
        L  = msg.size();
        nb = L / 136 + 1;
        p  = msg;
        p.push_back(8'h01);
        while (p.size() < nb * 136) p.push_back(8'h00);
        p[nb*136-1] = p[nb*136-1] | 8'h80;
        for (int j = 0; j < nb * 34; j++) begin
            tx_w.push_back({p[4*j], p[4*j+1], p[4*j+2], p[4*j+3]});
            tx_lb.push_back(j >= (nb - 1) * 34);
        end
        for (int i = 0; i < L / 4; i++)
            exp_q.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3], 3'd4, 1'b0});
        r = L % 4;
        t = 32'h0;
        for (int b = 0; b < r; b++) t[31-8*b -: 8] = msg[4*(L/4)+b];
        exp_q.push_back({t, 3'(r), 1'b1});
        perr_base = perr_cnt;
    endtask

    // Push every queued word through the input handshake (bounded waits).
    task automatic drive_all();
        int waitc;
        while (tx_w.size() > 0) begin
            if (gap_en && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in            = tx_w[0];
            in_last_block = tx_lb[0];
            in_valid      = 1'b1;
            waitc = 0;
            @(negedge clk);
            while (!in_ready && waitc < 400) begin
                @(negedge clk);
                waitc++;
            end
            chk("in_handshake", 64'(in_ready), 64'd1);
            if (!in_ready) begin
                tx_w.delete();
                tx_lb.delete();
            end else begin
                @(posedge clk);
                #1;
                void'(tx_w.pop_front());
                void'(tx_lb.pop_front());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_check();
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("beat", 64'(got_q[i]), 64'(exp_q[i]));
        chk("no_pad_error", 64'(perr_cnt - perr_base), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_msg();
        int   L;
        logic zero_grp;
        L = $urandom_range(0, 300);
        if ($urandom_range(0, 3) == 0) L = 134 + $urandom_range(0, 3);
        msg.delete();
        zero_grp = 1'b0;
        for (int i = 0; i < L; i++) begin
            if ((i % 4) == 0) zero_grp = ($urandom_range(0, 2) == 0);
            msg.push_back(zero_grp ? 8'h00 : 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic run_msg();
        load_msg();
        drive_all();
        finish_check();
    endtask

    initial begin
        int nlast;
        reset = 1'b0;
        in = 32'h0;
        in_valid = 1'b0;
        in_last_block = 1'b0;
        e_first = '{32'h0100_0000, 32'h0200_0000, 32'h0000_0000};
        e_last  = '{32'h0000_0000, 32'h0000_0080, 32'h0000_0280};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_pad_error", 64'(pad_error), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out_bytes", 64'(out_bytes), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed messages.
        rdy_mode = 0;
        msg.delete();
        run_msg();
        rdy_mode = 1;
        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};
        run_msg();
        msg.delete();
        for (int i = 0; i < 132; i++) msg.push_back(8'($urandom_range(1, 255)));
        msg.push_back(8'hAA);
        msg.push_back(8'hBB);
        msg.push_back(8'hCC);
        run_msg();
        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00};
        run_msg();

        // Two blocks with a 5-cycle sink stall mid-stream.
        rdy_mode = 0;
        gap_en = 1'b0;
        @(posedge clk);
        #1;
        msg.delete();
        for (int j = 0; j < 34; j++) begin
            msg.push_back(8'h00);
            msg.push_back(8'h00);
            msg.push_back(8'h00);
            msg.push_back(8'(j));
        end
        load_msg();
        fork
            drive_all();
            begin
                repeat (12) @(negedge clk);
                rdy_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                end
                rdy_mode = 0;
            end
        join
        finish_check();
        gap_en = 1'b1;
        rdy_mode = 1;

        // Malformed padding, each followed by a good message.
        for (int e = 0; e < 3; e++) begin
            tx_w.push_back(e_first[e]);
            tx_lb.push_back(1'b1);
            for (int j = 1; j < 33; j++) begin
                tx_w.push_back(32'h0);
                tx_lb.push_back(1'b1);
            end
            tx_w.push_back(e_last[e]);
            tx_lb.push_back(1'b1);
            perr_base = perr_cnt;
            drive_all();
            chk("err_pulse_now", 64'(pad_error), 64'd1);
            repeat (6) @(posedge clk);
            #1;
            chk("err_pulse_cnt", 64'(perr_cnt - perr_base), 64'd1);
            nlast = 0;
            foreach (got_q[i]) if (got_q[i][0]) nlast++;
            chk("err_no_last", 64'(nlast), 64'd0);
            got_q.delete();
            rand_msg();
            run_msg();
        end

        // Reset while replaying a zero run.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        tx_w  = '{32'h0, 32'h0, 32'h0, 32'h0100_0000};
        tx_lb = '{1'b1, 1'b1, 1'b1, 1'b1};
        drive_all();
        repeat (3) @(posedge clk);
        #1;
        chk("zero_out_valid", 64'(out_valid), 64'd1);
        chk("zero_out_bytes", 64'(out_bytes), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_last", 64'(out_last), 64'd0);
        chk("arst_pad_error", 64'(pad_error), 64'd0);
        chk("arst_out", 64'(out), 64'd0);
        chk("arst_out_bytes", 64'(out_bytes), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rdy_mode = 1;
        got_q.delete();
        @(posedge clk);
        #1;
        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};
        run_msg();

        // Randomized messages.
        for (int k = 0; k < 20; k++) begin
            rand_msg();
            run_msg();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_depadder.md
Name: keccak_depadder

Overview:
- Receive-side counterpart of the core's input padder: takes a stream of padded 32-bit words and outputs the original message words.
- The input stream is grouped into RATE_WORDS-word blocks, padded Keccak pad10*1 style: first pad byte 0x01, final block byte has bit 0x80 set, and 0x81 is legal when both coincide.
- The block removes the padding, marks the last message word with its valid byte count, and flags malformed padding.
- It sits on the loopback/verification path and on the message-replay path next to the padder.

Parameters:
- RATE_WORDS, 34, 32-bit words per block (rate 1088 bits).
- CNT_W, 6, width of the word-index and zero-run counters; must satisfy 2^CNT_W > RATE_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  32  padded word; byte0 = in[31:24].
- in_valid  in  1  input word valid.
- in_last_block  in  1  current word belongs to the final block; held constant for the whole block.
- in_ready  out  1  input handshake; a word is accepted when in_valid && in_ready.
- out  out  32  message word; bytes at or beyond out_bytes are forced to zero.
- out_bytes  out  3  valid bytes in the word, 0..4; always 4 unless out_last.
- out_last  out  1  last beat of the message.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- pad_error  out  1  one-cycle pulse when padding is malformed.

Behaviour:
- Reset (async, reset low):
  - state=RUN; out_valid, out_last, pad_error=0; out, out_bytes=0.
  - pend_v=0, pend_fin=0, zcnt=0, widx=0.
- Registered outputs:
  - While out_valid && !out_ready, out, out_bytes and out_last hold stable.
  - A beat transfers on out_valid && out_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). No other combinational input-to-output path.
- widx counts accepted words and wraps at RATE_WORDS-1 to 0. blk_end = (widx==RATE_WORDS-1).
- Non-final-block word w accepted:
  - If pend_v, emit pend (bytes 4, last 0).
  - Then pend<=w, pend_v=1, pend_fin=0.
- Final-block word w that is not blk_end, w!=0:
  - If pend_v, emit pend (bytes 4).
  - If zcnt>0: hold<=w, go ZERO. Otherwise pend<=w, pend_fin=1.
- Final-block word w that is not blk_end, w==0: zcnt++, nothing emitted. Zero words are counted, never stored.
- Final-block word at blk_end: w'=w with bit 7 cleared.
  - If w[7]==0: error.
  - If w'!=0: its last nonzero byte k must equal 0x01, otherwise error.
    - If pend_v, emit pend (bytes 4).
    - hold<=w'. Go ZERO if zcnt>0, otherwise go TAIL.
  - If w'==0: pend_v && pend_fin is required, otherwise error.
    - The last nonzero byte k of pend must be 0x01, otherwise error.
    - Emit pend truncated with out_bytes=k, last=1. The zero run is discarded.
    - Clear pend_v and zcnt.
- ZERO state:
  - Emit one zero word (bytes 4) per free output slot; zcnt--.
  - At zcnt==0: return to RUN with pend<=hold (mid-block case), or go to TAIL (blk_end case).
- TAIL state:
  - Emit hold truncated: out_bytes=k, bytes k..3 zeroed, out_last=1.
  - Clear pend_v and zcnt; go to RUN.
- Empty message or pad at byte 0: a last beat with out_bytes=0 and out=0 is legal.
- Error handling:
  - pad_error pulses in the cycle after acceptance of the final word.
  - pend, hold and zcnt are discarded, no out_last is produced, state=RUN, widx=0.
- Reset mid-operation aborts all state immediately; no partial beat is completed.
- Throughput is at most 1 word/cycle. Input stalls during ZERO and TAIL.

Decomposition:
- Shared package keccak_pkg:
  - RATE_WORDS.
  - Pad byte constants PAD_FIRST=8'h01 and PAD_LAST=8'h80.
  - State enum {RUN, ZERO, TAIL}.
- Sub-module keccak_last_byte: combinational; given a 32-bit word, returns the index of the last nonzero byte, a nonzero flag, and the truncated word for that index.

Test Plan:
- Empty message: final block with word0=01000000, words 1..32=0, word33=00000080 -> one beat out=0, bytes=0, last=1, no pad_error.
- Message 11223344 55667788 AA: words 11223344, 55667788, AA010000, 30 zero words, 00000080 -> beats 11223344/4, 55667788/4, AA000000/1 last.
- 135-byte message: 33 data words then word33=AABBCC81 -> 33 beats of 4 bytes, then AABBCC00/3 last.
- Message ending in zeros: 11223344, 00000000, 00000000, 01000000, zeros, 00000080 -> 11223344, 0, 0 (4 bytes each), then 00000000/0 last. ZERO state is exercised.
- Two blocks (first non-final, 34 words 0..33) with out_ready low for 5 cycles mid-stream -> 34 pass-through beats in order, outputs stable while stalled, in_ready low during the stall.
- Malformed padding:
  - word33=00000000 -> pad_error one cycle, no last beat; the next valid message decodes correctly.
  - Last nonzero byte 0x02 -> pad_error.
  - reset asserted during ZERO -> all outputs 0 immediately.
